// File: rtl/gcd_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : gcd_unit_param
// Purpose  : Parametrised GCD engine with valid/ready request and response
//            handshakes. The algorithm is chosen at elaboration time:
//            subtractive Euclid (ALGO=0) or binary Stein (ALGO=1). The engine
//            also reports how many CALC cycles each operand pair took.
// Ports    : clk         - rising-edge clock
//            reset       - asynchronous, active-low reset
//            req_val     - request operands valid
//            req_rdy     - engine can accept a request (IDLE, out of reset)
//            req_a/req_b - operands, WIDTH bits
//            resp_val    - result valid (DONE state)
//            resp_rdy    - consumer accepts the result
//            resp_gcd    - gcd(a,b); gcd(x,0)=x; gcd(0,0)=0
//            resp_cycles - CALC cycles used, saturating at 2^CNT_W-1
//            resp_zero   - both operands were zero
// Revision : 1.0 - initial release
// ============================================================================
module gcd_unit_param #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8,
    parameter int ALGO  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [WIDTH-1:0] resp_gcd,
    output logic [CNT_W-1:0] resp_cycles,
    output logic             resp_zero
);

    // K holds the common power of two factored out by Stein; it can reach at
    // most WIDTH, so it needs ceil(log2(WIDTH+1)) bits.
    localparam int               c_K_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [c_K_W-1:0] r_k, w_k_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_zflag, w_zflag_nxt;
    logic [WIDTH-1:0] r_gcd, w_gcd_nxt;
    logic [CNT_W-1:0] r_cycles, w_cycles_nxt;
    logic             r_zero, w_zero_nxt;

    logic [CNT_W-1:0] w_count_inc;
    logic [WIDTH-1:0] w_diff_ab;
    logic [WIDTH-1:0] w_diff_ba;
    logic [WIDTH-1:0] w_shl_a;
    logic [WIDTH-1:0] w_shl_b;

    // Saturating iteration counter value for this CALC cycle.
    assign w_count_inc = (r_count == c_CNT_MAX) ? r_count : r_count + 1'b1;
    assign w_diff_ab   = r_a - r_b;
    assign w_diff_ba   = r_b - r_a;
    // Shifted result stays in WIDTH bits: the true gcd always fits.
    assign w_shl_a     = r_a << r_k;
    assign w_shl_b     = r_b << r_k;

    assign req_rdy     = (r_state == S_IDLE) && reset;
    assign resp_val    = (r_state == S_DONE);
    assign resp_gcd    = r_gcd;
    assign resp_cycles = r_cycles;
    assign resp_zero   = r_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_count  <= '0;
            r_zflag  <= 1'b0;
            r_gcd    <= '0;
            r_cycles <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_k      <= w_k_nxt;
            r_count  <= w_count_nxt;
            r_zflag  <= w_zflag_nxt;
            r_gcd    <= w_gcd_nxt;
            r_cycles <= w_cycles_nxt;
            r_zero   <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_k_nxt      = r_k;
        w_count_nxt  = r_count;
        w_zflag_nxt  = r_zflag;
        w_gcd_nxt    = r_gcd;
        w_cycles_nxt = r_cycles;
        w_zero_nxt   = r_zero;

        case (r_state)
            S_IDLE: begin
                if (req_val && req_rdy) begin
                    w_a_nxt     = req_a;
                    w_b_nxt     = req_b;
                    w_k_nxt     = '0;
                    w_count_nxt = '0;
                    w_zflag_nxt = (req_a == '0) && (req_b == '0);
                    w_state_nxt = S_CALC;
                end
            end

            S_CALC: begin
                w_count_nxt = w_count_inc;
                if (ALGO == 0) begin
                    if (r_b == '0) begin
                        w_gcd_nxt   = r_a;
                        w_state_nxt = S_DONE;
                    end else if (r_a < r_b) begin
                        w_a_nxt = r_b;
                        w_b_nxt = r_a;
                    end else begin
                        w_a_nxt = w_diff_ab;
                    end
                end else begin
                    if (r_a == '0) begin
                        w_gcd_nxt   = w_shl_b;
                        w_state_nxt = S_DONE;
                    end else if (r_b == '0) begin
                        w_gcd_nxt   = w_shl_a;
                        w_state_nxt = S_DONE;
                    end else if (!r_a[0] && !r_b[0]) begin
                        w_a_nxt = r_a >> 1;
                        w_b_nxt = r_b >> 1;
                        w_k_nxt = r_k + 1'b1;
                    end else if (!r_a[0]) begin
                        w_a_nxt = r_a >> 1;
                    end else if (!r_b[0]) begin
                        w_b_nxt = r_b >> 1;
                    end else if (r_a >= r_b) begin
                        // Both odd: the difference is even, halve it at once.
                        w_a_nxt = w_diff_ab >> 1;
                    end else begin
                        w_b_nxt = w_diff_ba >> 1;
                    end
                end
                // The terminating cycle is included in the reported count.
                if (w_state_nxt == S_DONE) begin
                    w_cycles_nxt = w_count_inc;
                    w_zero_nxt   = r_zflag;
                end
            end

            S_DONE: begin
                if (resp_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_unit_param
// Purpose  : Directed self-checking bench for gcd_unit_param. Three engines
//            share one request stream: Euclid/16-bit, Stein/16-bit and
//            Euclid/32-bit with a 4-bit saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_unit_param;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic        resp_rdy;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic        req_rdy0, resp_val0, resp_zero0;
    logic [15:0] resp_gcd0;
    logic [7:0]  resp_cycles0;
    logic        req_rdy1, resp_val1, resp_zero1;
    logic [15:0] resp_gcd1;
    logic [7:0]  resp_cycles1;
    logic        req_rdy2, resp_val2, resp_zero2;
    logic [31:0] resp_gcd2;
    logic [3:0]  resp_cycles2;

    int n_cmp = 0;
    int n_err = 0;

    gcd_unit_param #(.WIDTH(16), .CNT_W(8), .ALGO(0)) u_euclid (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy0),
        .req_a(req_a[15:0]), .req_b(req_b[15:0]),
        .resp_val(resp_val0), .resp_rdy(resp_rdy),
        .resp_gcd(resp_gcd0), .resp_cycles(resp_cycles0), .resp_zero(resp_zero0)
    );

    gcd_unit_param #(.WIDTH(16), .CNT_W(8), .ALGO(1)) u_stein (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy1),
        .req_a(req_a[15:0]), .req_b(req_b[15:0]),
        .resp_val(resp_val1), .resp_rdy(resp_rdy),
        .resp_gcd(resp_gcd1), .resp_cycles(resp_cycles1), .resp_zero(resp_zero1)
    );

    gcd_unit_param #(.WIDTH(32), .CNT_W(4), .ALGO(0)) u_sat (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy2),
        .req_a(req_a), .req_b(req_b),
        .resp_val(resp_val2), .resp_rdy(resp_rdy),
        .resp_gcd(resp_gcd2), .resp_cycles(resp_cycles2), .resp_zero(resp_zero2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One transaction on all three engines. hold>0 keeps resp_rdy low for
    // that many extra cycles in DONE while pulsing req_val.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input int hold,
                       input logic [31:0] g0, input logic [31:0] c0,
                       input logic [31:0] g1, input logic [31:0] c1,
                       input logic [31:0] g2, input logic [31:0] c2,
                       input logic z);
        int n;
        int l0;
        int l1;
        int l2;
        @(negedge clk);
        chk("req_rdy_before", {29'd0, req_rdy2, req_rdy1, req_rdy0}, 32'd7);
        req_a   = a;
        req_b   = b;
        req_val = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        n  = 1;
        l0 = 0;
        l1 = 0;
        l2 = 0;
        while ((l0 == 0 || l1 == 0 || l2 == 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (resp_val0 && l0 == 0) l0 = n;
            if (resp_val1 && l1 == 0) l1 = n;
            if (resp_val2 && l2 == 0) l2 = n;
        end
        chk("latency_euclid", l0, c0 + 1);
        chk("latency_stein", l1, c1 + 1);
        chk("resp_val_sat", {31'd0, l2 != 0}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_val = i[0];
            req_a   = 32'd77;
            req_b   = 32'd7;
            @(posedge clk);
            #1;
            chk("bp_resp_val", {31'd0, resp_val0}, 32'd1);
            chk("bp_resp_gcd", resp_gcd0, g0);
            chk("bp_req_rdy", {31'd0, req_rdy0}, 32'd0);
        end
        req_val = 1'b0;
        chk("gcd_euclid", resp_gcd0, g0);
        chk("cycles_euclid", resp_cycles0, c0);
        chk("zero_euclid", {31'd0, resp_zero0}, {31'd0, z});
        chk("gcd_stein", resp_gcd1, g1);
        chk("cycles_stein", resp_cycles1, c1);
        chk("zero_stein", {31'd0, resp_zero1}, {31'd0, z});
        chk("gcd_sat", resp_gcd2, g2);
        chk("cycles_sat", resp_cycles2, c2);
        chk("zero_sat", {31'd0, resp_zero2}, {31'd0, z});
        @(negedge clk);
        resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        resp_rdy = 1'b0;
        chk("req_rdy_after_hs", {29'd0, req_rdy2, req_rdy1, req_rdy0}, 32'd7);
        chk("resp_val_after_hs", {29'd0, resp_val2, resp_val1, resp_val0}, 32'd0);
    endtask

    initial begin
        int seen;
        reset    = 1'b0;
        req_val  = 1'b0;
        resp_rdy = 1'b0;
        req_a    = '0;
        req_b    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", {29'd0, req_rdy2, req_rdy1, req_rdy0}, 32'd0);
        chk("rst_resp_val", {29'd0, resp_val2, resp_val1, resp_val0}, 32'd0);
        chk("rst_resp_gcd", resp_gcd0, 32'd0);
        chk("rst_resp_cycles", resp_cycles0, 32'd0);
        chk("rst_resp_zero", {31'd0, resp_zero0}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_release_rdy", {29'd0, req_rdy2, req_rdy1, req_rdy0}, 32'd7);

        //   a    b  hold  euclid    stein     sat       zero
        run(6,   18,  0,   6, 6,     6, 4,     6, 6,     1'b0);
        run(4,    6,  0,   2, 7,     2, 5,     2, 7,     1'b0);
        run(48, 180,  0,  12, 12,   12, 9,    12, 12,    1'b0);
        run(0,    0,  0,   0, 1,     0, 1,     0, 1,     1'b1);
        run(0,    5,  0,   5, 2,     5, 1,     5, 2,     1'b0);
        run(9,    0,  0,   9, 1,     9, 1,     9, 1,     1'b0);
        run(1,  100,  0,   1, 103,   1, 8,     1, 15,    1'b0);
        // Backpressure with ignored request pulses
        run(6,   18,  5,   6, 6,     6, 4,     6, 6,     1'b0);

        // Reset asserted mid-CALC discards the computation
        @(negedge clk);
        req_a   = 32'd1;
        req_b   = 32'd100;
        req_val = 1'b1;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midcalc_rst_rdy", {29'd0, req_rdy2, req_rdy1, req_rdy0}, 32'd0);
        chk("midcalc_rst_val", {29'd0, resp_val2, resp_val1, resp_val0}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midcalc_idle_rdy", {29'd0, req_rdy2, req_rdy1, req_rdy0}, 32'd7);
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (resp_val0 || resp_val1 || resp_val2) seen++;
        end
        chk("midcalc_no_resp", seen, 32'd0);
        run(9, 0, 0, 9, 1, 9, 1, 9, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
